// File: rtl/uart_tx_pkg.sv
// Shared types and frame-format helpers for the UART transmit engine.
package uart_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  // Number of data bits in a character: 5..8.
  function automatic logic [3:0] word_bits(input logic [1:0] wls);
    return 4'd5 + {2'b00, wls};
  endfunction

  // Length of the stop period in baud ticks.
  function automatic int unsigned stop_ticks(input logic stb, input logic [1:0] wls,
                                             input int unsigned oversample);
    if (!stb) return oversample;
    if (wls == 2'b00) return oversample + oversample / 2;
    return 2 * oversample;
  endfunction

  // Parity bit over the used data bits; stick parity overrides the XOR.
  function automatic logic parity_bit(input logic [7:0] data, input logic [1:0] wls,
                                      input logic eps, input logic sp);
    logic [7:0] mask;
    mask = 8'hFF >> (2'd3 - wls);
    if (sp) return ~eps;
    return eps ? ^(data & mask) : ~^(data & mask);
  endfunction

endpackage

// File: rtl/uart_tx_tickcnt.sv
// Clearable baud-tick counter; tc marks the tick that completes the current period.
module uart_tx_tickcnt #(
  parameter int W = 6
) (
  input  logic         CLK,
  input  logic         RSTN,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] limit,
  output logic         tc
);

  logic [W-1:0] count;

  assign tc = en & ~clr & (count == limit - W'(1));

  // Count enabled ticks, wrapping to zero when the period completes.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      count <= '0;
    end else if (clr || tc) begin
      count <= '0;
    end else if (en) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/uart_tx_engine.sv
// UART transmit engine: serialises one character per handshake onto TXD.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | line high (or low under break), DIN_READY asserted
// START  | start bit, TXD low for one bit period
// DATA   | data bits LSB first, one bit period each
// PARITY | optional parity bit, one bit period
// STOP   | stop period of 1, 1.5 or 2 bit periods, then TX_DONE
module uart_tx_engine
  import uart_tx_pkg::*;
#(
  parameter int OVERSAMPLE = 16
) (
  input  logic       CLK,
  input  logic       RSTN,
  input  logic       CLEAR,
  input  logic       BAUDCE,
  input  logic [7:0] DIN,
  input  logic       DIN_VALID,
  output logic       DIN_READY,
  input  logic [1:0] WLS,
  input  logic       STB,
  input  logic       PEN,
  input  logic       EPS,
  input  logic       SP,
  input  logic       BC,
  output logic       TXD,
  output logic       BUSY,
  output logic       TX_DONE
);

  localparam int CNT_W = $clog2(2 * OVERSAMPLE + 1);
  localparam logic [CNT_W-1:0] BIT_TICKS = CNT_W'(OVERSAMPLE);

  tx_state_t        state;
  logic [7:0]       shreg;
  logic [1:0]       wls_q;
  logic             stb_q;
  logic             pen_q;
  logic             par_q;
  logic [2:0]       bitcnt;
  logic [CNT_W-1:0] limit;
  logic             tc;
  logic             cnt_clr;
  logic             accept;
  logic             last_bit;

  assign accept   = DIN_VALID & DIN_READY & ~CLEAR & (state == IDLE);
  assign cnt_clr  = CLEAR | (state == IDLE);
  assign limit    = (state == STOP) ? CNT_W'(stop_ticks(stb_q, wls_q, OVERSAMPLE)) : BIT_TICKS;
  assign last_bit = ({1'b0, bitcnt} == word_bits(wls_q) - 4'd1);

  uart_tx_tickcnt #(.W(CNT_W)) u_tickcnt (
    .CLK   (CLK),
    .RSTN  (RSTN),
    .clr   (cnt_clr),
    .en    (BAUDCE),
    .limit (limit),
    .tc    (tc)
  );

  // Frame sequencer; TXD is registered from the level of the state being entered.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state     <= IDLE;
      TXD       <= 1'b1;
      DIN_READY <= 1'b0;
      BUSY      <= 1'b0;
      TX_DONE   <= 1'b0;
      shreg     <= '0;
      wls_q     <= '0;
      stb_q     <= 1'b0;
      pen_q     <= 1'b0;
      par_q     <= 1'b0;
      bitcnt    <= '0;
    end else begin
      TX_DONE <= 1'b0;
      if (CLEAR) begin
        state     <= IDLE;
        TXD       <= ~BC;
        DIN_READY <= 1'b1;
        BUSY      <= 1'b0;
        bitcnt    <= '0;
      end else begin
        case (state)
          IDLE: begin
            DIN_READY <= ~accept;
            BUSY      <= accept;
            if (accept) begin
              state  <= START;
              TXD    <= 1'b0;
              shreg  <= DIN;
              wls_q  <= WLS;
              stb_q  <= STB;
              pen_q  <= PEN;
              par_q  <= parity_bit(DIN, WLS, EPS, SP);
              bitcnt <= '0;
            end else begin
              TXD <= ~BC;
            end
          end
          START: begin
            if (tc) begin
              state  <= DATA;
              bitcnt <= '0;
              TXD    <= ~BC & shreg[0];
            end else begin
              TXD <= 1'b0;
            end
          end
          DATA: begin
            if (tc) begin
              shreg  <= {1'b0, shreg[7:1]};
              bitcnt <= bitcnt + 3'd1;
              if (last_bit) begin
                if (pen_q) begin
                  state <= PARITY;
                  TXD   <= ~BC & par_q;
                end else begin
                  state <= STOP;
                  TXD   <= ~BC;
                end
              end else begin
                TXD <= ~BC & shreg[1];
              end
            end else begin
              TXD <= ~BC & shreg[0];
            end
          end
          PARITY: begin
            if (tc) begin
              state <= STOP;
              TXD   <= ~BC;
            end else begin
              TXD <= ~BC & par_q;
            end
          end
          STOP: begin
            TXD <= ~BC;
            if (tc) begin
              state     <= IDLE;
              TX_DONE   <= 1'b1;
              BUSY      <= 1'b0;
              DIN_READY <= 1'b1;
            end
          end
          default: begin
            state <= IDLE;
            TXD   <= ~BC;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_engine.sv
// Self-checking bench for uart_tx_engine.
module tb_uart_tx_engine;

  localparam int OS = 16;

  logic       CLK = 1'b0;
  logic       RSTN = 1'b0;
  logic       CLEAR = 1'b0;
  logic       BAUDCE = 1'b1;
  logic [7:0] DIN = 8'h00;
  logic       DIN_VALID = 1'b0;
  logic       DIN_READY;
  logic [1:0] WLS = 2'b11;
  logic       STB = 1'b0;
  logic       PEN = 1'b0;
  logic       EPS = 1'b0;
  logic       SP = 1'b0;
  logic       BC = 1'b0;
  logic       TXD;
  logic       BUSY;
  logic       TX_DONE;

  always #5 CLK = ~CLK;

  uart_tx_engine #(.OVERSAMPLE(OS)) dut (
    .CLK(CLK), .RSTN(RSTN), .CLEAR(CLEAR), .BAUDCE(BAUDCE),
    .DIN(DIN), .DIN_VALID(DIN_VALID), .DIN_READY(DIN_READY),
    .WLS(WLS), .STB(STB), .PEN(PEN), .EPS(EPS), .SP(SP), .BC(BC),
    .TXD(TXD), .BUSY(BUSY), .TX_DONE(TX_DONE)
  );

  typedef struct {
    logic [7:0] d;
    logic [1:0] wls;
    logic       stb;
    logic       pen;
    logic       eps;
    logic       sp;
    int         exp_cyc;
    int         exp_par;
  } vec_t;

  vec_t tbl[9];
  int   checks = 0;
  int   errors = 0;
  int   bper = 1;
  int   bphase = 0;
  int   seg_lvl[$];
  int   seg_len[$];
  int   par_idx;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_baud(input int p);
    bper = p;
    bphase = 0;
    BAUDCE = 1'b1;
  endtask

  // one clock; outputs sampled 1 time unit after the rising edge
  task automatic cyc();
    @(posedge CLK);
    #1;
    bphase = (bphase + 1) % bper;
    BAUDCE = (bphase == 0);
  endtask

  // Frame as a list of (level, length in ticks) segments
  function automatic void build_frame(input logic [7:0] d, input logic [1:0] wls,
                                      input logic stb, input logic pen,
                                      input logic eps, input logic sp);
    int wb;
    int x;
    wb = 5 + int'(wls);
    x = 0;
    seg_lvl.delete();
    seg_len.delete();
    par_idx = -1;
    seg_lvl.push_back(0); seg_len.push_back(OS);
    for (int i = 0; i < wb; i++) begin
      seg_lvl.push_back(int'(d[i]));
      seg_len.push_back(OS);
      x = x ^ int'(d[i]);
    end
    if (pen) begin
      par_idx = seg_lvl.size();
      seg_lvl.push_back(sp ? int'(!eps) : (eps ? x : 1 - x));
      seg_len.push_back(OS);
    end
    seg_lvl.push_back(1);
    seg_len.push_back(!stb ? OS : (wls == 2'b00 ? (OS * 3) / 2 : 2 * OS));
  endfunction

  function automatic int seg_at(input int t);
    int acc;
    acc = 0;
    foreach (seg_len[i]) begin
      acc += seg_len[i];
      if (t < acc) return i;
    end
    return -1;
  endfunction

  task automatic wait_accept(input string tag, output int waited, output bit ok);
    bit acc;
    acc = 1'b0;
    waited = 0;
    while (!acc && waited < 2000) begin
      acc = DIN_VALID && DIN_READY;
      cyc();
      waited++;
    end
    ok = acc;
    if (!acc) chk({tag, " accept timeout"}, 0, 1);
  endtask

  // Sends one frame and checks {TXD,TX_DONE,BUSY,DIN_READY} every cycle against the model.
  task automatic run_frame(input logic [7:0] d, input logic [1:0] wls, input logic stb,
                           input logic pen, input logic eps, input logic sp,
                           input string tag, output int frame_cyc, output int par_seen,
                           output int waited);
    int tot, t, s, e;
    bit b, ok;
    DIN = d; WLS = wls; STB = stb; PEN = pen; EPS = eps; SP = sp;
    DIN_VALID = 1'b1;
    build_frame(d, wls, stb, pen, eps, sp);
    tot = 0;
    foreach (seg_len[i]) tot += seg_len[i];
    frame_cyc = 0;
    par_seen = -1;
    wait_accept(tag, waited, ok);
    if (!ok) return;
    DIN = 8'($urandom); WLS = 2'($urandom); STB = 1'($urandom);
    PEN = 1'($urandom); EPS = 1'($urandom); SP = 1'($urandom);
    chk({tag, " accept"}, int'({TXD, TX_DONE, BUSY, DIN_READY}), 4'b0010);
    t = 0;
    while (t < tot) begin
      b = BAUDCE;
      cyc();
      frame_cyc++;
      if (b) t++;
      if (t < tot) begin
        s = seg_at(t);
        if (s == par_idx) par_seen = int'(TXD);
        e = {(BC ? 1'b0 : 1'(seg_lvl[s])), 3'b010};
        chk($sformatf("%s cycle %0d", tag, frame_cyc), int'({TXD, TX_DONE, BUSY, DIN_READY}), e);
      end
    end
    chk({tag, " done"}, int'({TXD, TX_DONE, BUSY, DIN_READY}), {~BC, 3'b101});
  endtask

  initial begin
    int fc, ps, wt, pulses, lows;
    bit ok;

    tbl[0] = '{8'hA5, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 160, -1};
    tbl[1] = '{8'h07, 2'd0, 1'b1, 1'b1, 1'b1, 1'b0, 136,  1};
    tbl[2] = '{8'h00, 2'd2, 1'b0, 1'b1, 1'b0, 1'b1, 160,  1};
    tbl[3] = '{8'h00, 2'd2, 1'b0, 1'b1, 1'b1, 1'b1, 160,  0};
    tbl[4] = '{8'h5A, 2'd1, 1'b1, 1'b1, 1'b0, 1'b0, 160,  0};
    tbl[5] = '{8'hFF, 2'd3, 1'b1, 1'b1, 1'b0, 1'b0, 192,  1};
    tbl[6] = '{8'hE3, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 128,  0};
    tbl[7] = '{8'h1F, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 112, -1};
    tbl[8] = '{8'h2A, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 128, -1};

    // reset state
    set_baud(1);
    repeat (3) cyc();
    chk("reset outputs", int'({TXD, TX_DONE, BUSY, DIN_READY}), 4'b1000);
    @(negedge CLK);
    RSTN = 1'b1;
    cyc();
    chk("ready after reset", int'({TXD, TX_DONE, BUSY, DIN_READY}), 4'b1001);

    // table of frame formats, sent back to back
    foreach (tbl[i]) begin
      run_frame(tbl[i].d, tbl[i].wls, tbl[i].stb, tbl[i].pen, tbl[i].eps, tbl[i].sp,
                $sformatf("tbl%0d", i), fc, ps, wt);
      chk($sformatf("tbl%0d frame length", i), fc, tbl[i].exp_cyc);
      chk($sformatf("tbl%0d parity bit", i), ps, tbl[i].exp_par);
      if (i > 0) chk($sformatf("tbl%0d gap", i), wt, 1);
    end
    DIN_VALID = 1'b0;
    repeat (3) cyc();

    // CLEAR in the third data bit
    DIN = 8'h3B; WLS = 2'b11; STB = 1'b0; PEN = 1'b0; DIN_VALID = 1'b1;
    wait_accept("clr", wt, ok);
    DIN_VALID = 1'b0;
    repeat (53) cyc();
    chk("clr before", int'({TXD, TX_DONE, BUSY, DIN_READY}), 4'b0010);
    CLEAR = 1'b1;
    cyc();
    chk("clr after", int'({TXD, TX_DONE, BUSY, DIN_READY}), 4'b1001);
    DIN_VALID = 1'b1;
    cyc();
    chk("clr beats accept", int'({TXD, TX_DONE, BUSY}), 3'b100);
    CLEAR = 1'b0;
    DIN_VALID = 1'b0;
    pulses = 0;
    lows = 0;
    repeat (200) begin
      cyc();
      if (TX_DONE) pulses++;
      if (!TXD) lows++;
    end
    chk("clr no done", pulses, 0);
    chk("clr line idle", lows, 0);
    run_frame(8'h3B, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, "post clr", fc, ps, wt);
    chk("post clr length", fc, 160);
    DIN_VALID = 1'b0;
    cyc();

    // break during a frame
    BC = 1'b1;
    run_frame(8'h55, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, "brk", fc, ps, wt);
    chk("brk length", fc, 160);
    DIN_VALID = 1'b0;
    BC = 1'b0;
    cyc();
    chk("brk released", int'(TXD), 1);

    // asynchronous reset mid-frame
    DIN = 8'h00; WLS = 2'b11; STB = 1'b0; PEN = 1'b0; DIN_VALID = 1'b1;
    wait_accept("rst", wt, ok);
    DIN_VALID = 1'b0;
    repeat (50) cyc();
    chk("rst busy before", int'({TXD, BUSY}), 2'b01);
    @(negedge CLK);
    RSTN = 1'b0;
    #1;
    chk("rst async", int'({TXD, TX_DONE, BUSY, DIN_READY}), 4'b1000);
    @(negedge CLK);
    RSTN = 1'b1;
    cyc();
    chk("rst released", int'({TXD, TX_DONE, BUSY, DIN_READY}), 4'b1001);

    // slow baud, three characters queued back to back
    set_baud(4);
    for (int k = 0; k < 3; k++) begin
      run_frame(8'h81 + 8'(k * 37), 2'b11, 1'b0, 1'b0, 1'b0, 1'b0,
                $sformatf("b2b%0d", k), fc, ps, wt);
      chk($sformatf("b2b%0d length", k), int'(fc >= 637 && fc <= 640), 1);
      if (k > 0) chk($sformatf("b2b%0d gap", k), wt, 1);
    end
    DIN_VALID = 1'b0;
    cyc();

    // randomized formats, baud rates, break and idle gaps
    for (int n = 0; n < 25; n++) begin
      int g;
      g = $urandom_range(0, 3);
      if (g > 0) DIN_VALID = 1'b0;
      BC = ($urandom_range(0, 7) == 0);
      for (int i = 0; i < g; i++) begin
        cyc();
        chk($sformatf("rnd%0d idle", n), int'({TXD, TX_DONE, BUSY}), {~BC, 2'b00});
      end
      set_baud($urandom_range(1, 3));
      run_frame(8'($urandom), 2'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                1'($urandom), $sformatf("rnd%0d", n), fc, ps, wt);
      chk($sformatf("rnd%0d gap", n), wt, 1);
    end
    DIN_VALID = 1'b0;
    BC = 1'b0;
    repeat (2) cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
